// File: rtl/stream_deserializer.sv
// Serial-to-parallel converter: assembles WIDTH-bit words from a gated bit stream
// and queues them in a DEPTH-entry FIFO with a valid/ready output and sticky overrun.
module stream_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_enable,
  input  logic                       serial_in,
  input  logic                       clear,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       overrun
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             word_done;
  logic             pop;
  logic             push;
  logic             full;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], serial_in};
    else           sr_next = {serial_in, sr[WIDTH-1:1]};
  end

  // Pointers carry one extra wrap bit, so their difference is the fill level.
  assign level     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (level == FULL_LEVEL);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign word_done = shift_enable && !clear && (bit_count == LAST_BIT);
  assign pop       = out_valid && out_ready;
  assign push      = word_done && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      bit_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (clear) begin
        sr        <= '0;
        bit_count <= '0;
      end else if (shift_enable) begin
        sr        <= sr_next;
        bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (clear)                  overrun <= 1'b0;
      else if (word_done && !push) overrun <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sr_next;
  end

endmodule

// File: tb/tb_stream_deserializer.sv
// Testbench for stream_deserializer: MSB-first and LSB-first instances share stimulus
// and are checked against a queue-based word model.
module tb_stream_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_enable, serial_in, clear, out_ready;
  logic [7:0] od_m, od_l;
  logic       ov_m, ov_l;
  logic [2:0] lv_m, lv_l;
  logic [2:0] bc_m, bc_l;
  logic       or_m, or_l;

  int checks = 0;
  int errors = 0;

  // Reference model: bit counter, per-ordering word accumulators, word queues.
  int         m_cnt;
  int         m_acc_m, m_acc_l;
  bit         m_ov;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  stream_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready),
    .level(lv_m), .bit_count(bc_m), .overrun(or_m)
  );

  stream_deserializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready),
    .level(lv_l), .bit_count(bc_l), .overrun(or_l)
  );

  task automatic model_reset();
    m_cnt = 0; m_acc_m = 0; m_acc_l = 0; m_ov = 1'b0;
    q_m.delete(); q_l.delete();
  endtask

  task automatic model_step(input logic se, input logic sin, input logic clr, input logic rdy);
    int pre;
    bit do_pop;
    pre    = q_m.size();
    do_pop = (pre > 0) && rdy;
    if (do_pop) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (clr) begin
      m_cnt = 0; m_acc_m = 0; m_acc_l = 0; m_ov = 1'b0;
    end else if (se) begin
      m_acc_m = (m_acc_m * 2 + int'(sin)) % 256;
      m_acc_l = m_acc_l + (int'(sin) << m_cnt);
      m_cnt   = m_cnt + 1;
      if (m_cnt == 8) begin
        if (pre < 4 || do_pop) begin
          q_m.push_back(8'(m_acc_m));
          q_l.push_back(8'(m_acc_l));
        end else begin
          m_ov = 1'b1;
        end
        m_cnt = 0; m_acc_m = 0; m_acc_l = 0;
      end
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
  task automatic tick(input logic se, input logic sin, input logic clr, input logic rdy);
    shift_enable = se; serial_in = sin; clear = clr; out_ready = rdy;
    @(posedge clk);
    model_step(se, sin, clr, rdy);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) tick(1'b1, w[i], 1'b0, rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1; shift_enable = 0; serial_in = 0; clear = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++; if (od_m !== 8'h00 || od_l !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h/%h expected 00", od_m, od_l); end
    checks++; if (ov_m !== 1'b0 || ov_l !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b expected 0", ov_m, ov_l); end
    checks++; if (lv_m !== 3'd0 || bc_m !== 3'd0) begin errors++; $display("FAIL reset_level_count: got %0d/%0d expected 0/0", lv_m, bc_m); end
    checks++; if (or_m !== 1'b0 || or_l !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b/%b expected 0", or_m, or_l); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bit_order();
    send_word(8'hA5, 1'b1);
    checks++; if (ov_m !== 1'b1 || od_m !== 8'hA5) begin errors++; $display("FAIL msb_a5: got valid=%b data=%h expected 1/a5", ov_m, od_m); end
    checks++; if (ov_l !== 1'b1 || od_l !== 8'hA5) begin errors++; $display("FAIL lsb_a5: got valid=%b data=%h expected 1/a5", ov_l, od_l); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (lv_m !== 3'd0 || bc_m !== 3'd0 || ov_m !== 1'b0) begin errors++; $display("FAIL a5_popped: got level=%0d count=%0d valid=%b expected 0/0/0", lv_m, bc_m, ov_m); end
    send_word(8'hF0, 1'b0);
    checks++; if (od_m !== 8'hF0) begin errors++; $display("FAIL msb_f0: got %h expected f0", od_m); end
    checks++; if (od_l !== 8'h0F) begin errors++; $display("FAIL lsb_0f: got %h expected 0f", od_l); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0);
    checks++; if (lv_m !== 3'd4 || or_m !== 1'b1) begin errors++; $display("FAIL overrun_full: got level=%0d overrun=%b expected 4/1", lv_m, or_m); end
    checks++; if (lv_l !== 3'd4 || or_l !== 1'b1) begin errors++; $display("FAIL overrun_full_lsb: got level=%0d overrun=%b expected 4/1", lv_l, or_l); end
    for (int w = 1; w <= 4; w++) begin
      checks++; if (od_m !== 8'(w)) begin errors++; $display("FAIL drain_msb_%0d: got %h expected %h", w, od_m, 8'(w)); end
      checks++; if (q_l.size() == 0 || od_l !== q_l[0]) begin errors++; $display("FAIL drain_lsb_%0d: got %h expected model head", w, od_l); end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (ov_m !== 1'b0 || od_m !== 8'h00) begin errors++; $display("FAIL drained_empty: got valid=%b data=%h expected 0/00", ov_m, od_m); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (or_m !== 1'b1 || lv_m !== 3'd0) begin errors++; $display("FAIL overrun_sticky: got overrun=%b level=%0d expected 1/0", or_m, lv_m); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (or_m !== 1'b0 || or_l !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b/%b expected 0", or_m, or_l); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_words [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    logic [7:0] w66;
    send_word(8'h11, 1'b0); send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0); send_word(8'h44, 1'b0);
    w66 = 8'h66;
    for (int i = 7; i >= 1; i--) tick(1'b1, w66[i], 1'b0, 1'b0);
    tick(1'b1, w66[0], 1'b0, 1'b1);
    checks++; if (lv_m !== 3'd4 || or_m !== 1'b0) begin errors++; $display("FAIL full_push_pop: got level=%0d overrun=%b expected 4/0", lv_m, or_m); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (od_m !== exp_words[i]) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, od_m, exp_words[i]); end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (ov_m !== 1'b0 || lv_l !== 3'd0) begin errors++; $display("FAIL full_drain_empty: got valid=%b level=%0d expected 0/0", ov_m, lv_l); end
  endtask

  task automatic test_idle_and_clear();
    logic [7:0] w = 8'h3C;
    logic [7:0] wf = 8'hF0;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, w[i], 1'b0, 1'b0);
      if (i > 0) begin
        int gaps = $urandom_range(0, 3);
        for (int g = 0; g < gaps; g++) begin
          tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
          checks++; if (bc_m !== 3'(8 - i)) begin errors++; $display("FAIL gap_hold: got count=%0d expected %0d", bc_m, 8 - i); end
        end
      end
    end
    checks++; if (od_m !== 8'h3C || lv_m !== 3'd1) begin errors++; $display("FAIL gapped_3c: got data=%h level=%0d expected 3c/1", od_m, lv_m); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bc_m !== 3'd3) begin errors++; $display("FAIL partial_count: got %0d expected 3", bc_m); end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bc_m !== 3'd0 || bc_l !== 3'd0) begin errors++; $display("FAIL clear_count: got %0d/%0d expected 0", bc_m, bc_l); end
    for (int i = 7; i >= 0; i--) tick(1'b1, wf[i], 1'b0, 1'b0);
    checks++; if (lv_m !== 3'd1 || od_m !== 8'hF0) begin errors++; $display("FAIL after_clear_f0: got level=%0d data=%h expected 1/f0", lv_m, od_m); end
    checks++; if (od_l !== 8'h0F) begin errors++; $display("FAIL after_clear_lsb: got %h expected 0f", od_l); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [7:0] w81 = 8'h81;
    send_word(8'h5A, 1'b0); send_word(8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    checks++; if (lv_m !== 3'd2 || bc_m !== 3'd5) begin errors++; $display("FAIL pre_reset_state: got level=%0d count=%0d expected 2/5", lv_m, bc_m); end
    #2 rst = 1'b1;
    #1;
    checks++; if (od_m !== 8'h00 || ov_m !== 1'b0 || lv_m !== 3'd0 || bc_m !== 3'd0 || or_m !== 1'b0)
      begin errors++; $display("FAIL async_reset_msb: got data=%h valid=%b level=%0d count=%0d ovr=%b expected all 0", od_m, ov_m, lv_m, bc_m, or_m); end
    checks++; if (od_l !== 8'h00 || ov_l !== 1'b0 || lv_l !== 3'd0 || bc_l !== 3'd0 || or_l !== 1'b0)
      begin errors++; $display("FAIL async_reset_lsb: got data=%h valid=%b level=%0d count=%0d ovr=%b expected all 0", od_l, ov_l, lv_l, bc_l, or_l); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 7; i >= 0; i--) tick(1'b1, w81[i], 1'b0, 1'b0);
    checks++; if (od_m !== 8'h81 || od_l !== 8'h81 || lv_m !== 3'd1) begin errors++; $display("FAIL post_reset_81: got %h/%h level=%0d expected 81/81/1", od_m, od_l, lv_m); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic se, sin, clr, rdy;
      logic [7:0] exp_m, exp_l;
      se  = ($urandom_range(0, 3) != 0);
      sin = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      tick(se, sin, clr, rdy);
      exp_m = (q_m.size() > 0) ? q_m[0] : 8'h00;
      exp_l = (q_l.size() > 0) ? q_l[0] : 8'h00;
      checks++; if (od_m !== exp_m || od_l !== exp_l) begin errors++; $display("FAIL rand_data cycle %0d: got %h/%h expected %h/%h", c, od_m, od_l, exp_m, exp_l); end
      checks++; if (ov_m !== (q_m.size() > 0) || lv_m !== 3'(q_m.size()) || lv_l !== 3'(q_l.size()))
        begin errors++; $display("FAIL rand_level cycle %0d: got valid=%b level=%0d/%0d expected %0d", c, ov_m, lv_m, lv_l, q_m.size()); end
      checks++; if (bc_m !== 3'(m_cnt) || bc_l !== 3'(m_cnt)) begin errors++; $display("FAIL rand_count cycle %0d: got %0d/%0d expected %0d", c, bc_m, bc_l, m_cnt); end
      checks++; if (or_m !== m_ov || or_l !== m_ov) begin errors++; $display("FAIL rand_overrun cycle %0d: got %b/%b expected %b", c, or_m, or_l, m_ov); end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_full_pop();
    test_idle_and_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
